dec_to_bcd_encoder: RTL and testbench

- Sequential decimal-to-BCD encoder; the reverse direction of the team's BCD-to-decimal decoder.
- Accepts 10 asynchronous decimal key lines (digit 0-9, active-high), synchronises and debounces them, and priority-encodes a stable press into a 4-bit BCD code.
- Delivers each press once over a valid/ready handshake.
- Sits between a keypad/switch bank and downstream digit logic (display, accumulator).

---
 rtl/dec_to_bcd_encoder.sv | 83 ++++++++
 tb/tb_dec_to_bcd_encoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dec_to_bcd_encoder.sv
// dec_to_bcd_encoder: debounced decimal-key to BCD encoder with valid/ready delivery
module dec_to_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key,
  input  logic       ready,
  output logic       valid,
  output logic [3:0] bcd,
  output logic       multi,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;
  state_t state, state_n;
  logic [9:0] s1, ks, pat, pat_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] bcd_n;
  logic multi_n;
  logic [7:0] pc_n;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  function automatic logic [3:0] hi_idx(input logic [9:0] p);
    hi_idx = '0;
    for (int i = 0; i < 10; i++) if (p[i]) hi_idx = 4'(i);
  endfunction
  always_comb begin
    state_n = state;
    pat_n = pat;
    cnt_n = cnt;
    bcd_n = bcd;
    multi_n = multi;
    pc_n = press_count;
    case (state)
      IDLE: if (ks != '0) begin
        pat_n = ks;
        cnt_n = CNT_W'(1);
        state_n = DEBOUNCE;
      end
      DEBOUNCE: if (ks == '0) state_n = IDLE;
      else if (ks != pat) begin
        pat_n = ks;
        cnt_n = CNT_W'(1);
      end else if (cnt == LIMIT) begin
        bcd_n = hi_idx(pat);
        multi_n = |(pat & (pat - 10'd1));
        state_n = EMIT;
      end else cnt_n = cnt + CNT_W'(1);
      EMIT: if (ready) begin
        pc_n = press_count + 8'd1;
        cnt_n = '0;
        state_n = RELEASE;
      end
      default: if (ks != '0) cnt_n = '0;
      else begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt_n == LIMIT) state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      s1 <= '0;
      ks <= '0;
      pat <= '0;
      cnt <= '0;
      valid <= 1'b0;
      bcd <= '0;
      multi <= 1'b0;
      press_count <= '0;
    end else begin
      state <= state_n;
      s1 <= key;
      ks <= s1;
      pat <= pat_n;
      cnt <= cnt_n;
      valid <= state_n == EMIT;
      bcd <= bcd_n;
      multi <= multi_n;
      press_count <= pc_n;
    end
endmodule

// File: tb/tb_dec_to_bcd_encoder.sv
// tb_dec_to_bcd_encoder: directed scoreboard bench for the debounced BCD encoder
module tb_dec_to_bcd_encoder;
  logic clk = 0, rst_n = 1, ready = 0;
  logic [9:0] key = '0;
  logic valid, multi;
  logic [3:0] bcd;
  logic [7:0] press_count;
  int checks = 0, errors = 0;
  logic [4:0] q[$];
  logic [7:0] exp_pc = '0;

  dec_to_bcd_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .ready(ready),
    .valid(valid), .bcd(bcd), .multi(multi), .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid;
    int n = 0;
    while (valid !== 1'b1 && n < 30) begin
      tick;
      n++;
    end
    chk("wait_valid", {15'd0, valid}, 16'd1);
  endtask

  task automatic press(input logic [9:0] k, input logic [3:0] b, input logic m);
    q.push_back({b, m});
    key = k;
    wait_valid;
    key = '0;
    repeat (7) tick;
  endtask

  // Scoreboard: every handshake pops one expected code; press_count tracked alongside.
  always @(negedge clk) if (rst_n) begin
    logic [4:0] e;
    checks++;
    assert (press_count === exp_pc) else begin
      errors++;
      $error("FAIL press_count observed=%0d expected=%0d", press_count, exp_pc);
    end
    if (valid) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed bcd=%0d expected no valid", bcd);
      end
      if (ready && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert ({bcd, multi} === e) else begin
          errors++;
          $error("FAIL code observed=%0d/%0b expected=%0d/%0b", bcd, multi, e[4:1], e[0]);
        end
        exp_pc++;
      end
    end
  end

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_pc", {8'd0, press_count}, 16'd0);
    repeat (2) tick;
    rst_n = 1;
    ready = 1;
    // single press, latency 7 edges, one-cycle valid
    tick;
    q.push_back({4'd5, 1'b0});
    key = 10'h020;
    repeat (6) tick;
    chk("lat_early", {15'd0, valid}, 16'd0);
    tick;
    chk("lat_valid", {15'd0, valid}, 16'd1);
    chk("lat_bcd", {12'd0, bcd}, 16'd5);
    chk("lat_multi", {15'd0, multi}, 16'd0);
    tick;
    chk("one_cycle", {15'd0, valid}, 16'd0);
    chk("pc_one", {8'd0, press_count}, 16'd1);
    repeat (10) tick;
    key = '0;
    repeat (7) tick;
    // bounce rejection
    key = 10'h008;
    repeat (2) tick;
    key = '0;
    tick;
    key = 10'h008;
    q.push_back({4'd3, 1'b0});
    repeat (6) tick;
    chk("bounce_early", {15'd0, valid}, 16'd0);
    tick;
    chk("bounce_valid", {15'd0, valid}, 16'd1);
    tick;
    key = '0;
    repeat (7) tick;
    // multi-key priority
    press(10'h201, 4'd9, 1'b1);
    press(10'h003, 4'd1, 1'b1);
    // backpressure
    ready = 0;
    q.push_back({4'd7, 1'b0});
    key = 10'h080;
    wait_valid;
    key = 10'h004;
    repeat (20) begin
      tick;
      chk("bp_valid", {15'd0, valid}, 16'd1);
      chk("bp_bcd", {12'd0, bcd}, 16'd7);
    end
    ready = 1;
    tick;
    chk("bp_drop", {15'd0, valid}, 16'd0);
    chk("bp_pc", {8'd0, press_count}, 16'd5);
    key = '0;
    repeat (7) tick;
    // asynchronous reset mid-EMIT
    ready = 0;
    q.push_back({4'd4, 1'b0});
    key = 10'h010;
    wait_valid;
    #2;
    q.delete();
    exp_pc = '0;
    rst_n = 0;
    #1;
    chk("arst_valid", {15'd0, valid}, 16'd0);
    chk("arst_bcd", {12'd0, bcd}, 16'd0);
    chk("arst_multi", {15'd0, multi}, 16'd0);
    chk("arst_pc", {8'd0, press_count}, 16'd0);
    key = '0;
    repeat (2) tick;
    rst_n = 1;
    ready = 1;
    repeat (15) tick;
    chk("post_rst_idle", {15'd0, valid}, 16'd0);
    // wrap after 256 presses
    repeat (256) press(10'h001, 4'd0, 1'b0);
    chk("wrap_pc", {8'd0, press_count}, 16'd0);
    // re-press before release debounce completes
    q.push_back({4'd0, 1'b0});
    key = 10'h001;
    wait_valid;
    key = '0;
    repeat (2) tick;
    key = 10'h001;
    repeat (15) begin
      tick;
      chk("repress_quiet", {15'd0, valid}, 16'd0);
    end
    key = '0;
    repeat (7) tick;
    press(10'h001, 4'd0, 1'b0);
    chk("repress_pc", {8'd0, press_count}, 16'd2);
    chk("queue_empty", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
